ifu_boot: RTL and testbench
===========================

IFU_BOOT -- requirements
Module: ifu_boot

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_3000, byte address of the first instruction word.
REQ-002 Parameter IM_DEPTH, default 1024, instruction-memory depth in 32-bit words.
REQ-003 The ports SHALL be as follows:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- ld_valid  input  1  loader word valid.
- ld_data  input  32  loader instruction word.
- ld_last  input  1  marks the final loader word; qualified by ld_valid.
- ld_ready  output  1  block accepts loader words.
- stall  input  1  hold PC this cycle.
- npc_sel  input  2  next-PC source: 00 seq, 01 branch, 10 jump, 11 jr.
- br_taken  input  1  branch condition result.
- ra_data  input  32  jr target register value.
- instr  output  32  instruction at pc.
- pc  output  32  current fetch address.
- pc_plus4  output  32  pc+4.
- run  output  1  high in RUN state.
- addr_err  output  1  sticky fetch-address error.

Function
REQ-004 The block SHALL implement states LOAD, RUN and HALT.
REQ-005 In LOAD, ld_ready SHALL be 1; in RUN and HALT, ld_ready SHALL be 0.
REQ-006 In LOAD, each cycle with ld_valid=1 SHALL write ld_data to IM[ld_ptr] and increment ld_ptr (0..IM_DEPTH-1).
REQ-007 A write with ld_last=1, or a write at ld_ptr=IM_DEPTH-1, SHALL move LOAD->RUN at that clock edge; further ld_valid is ignored.
REQ-008 IM words never written SHALL read as 32'h0000_0000 (nop); the whole IM SHALL be cleared on reset.
REQ-009 instr SHALL be IM[(pc-PC_RESET)>>2], combinational from pc, in RUN; instr SHALL be 0 in LOAD and HALT.
REQ-010 pc_plus4 SHALL equal pc+32'd4, with 32-bit wrap.
REQ-011 In RUN with stall=1, pc SHALL hold regardless of npc_sel.
REQ-012 In RUN with stall=0, the next pc SHALL be:
- npc_sel 00: pc_plus4.
- npc_sel 01 with br_taken=1: pc_plus4 + (sign-extended instr[15:0] << 2).
- npc_sel 01 with br_taken=0: pc_plus4.
- npc_sel 10: {pc_plus4[31:28], instr[25:0], 2'b00}.
- npc_sel 11: ra_data.
REQ-013 If the computed next pc has [1:0]!=0 or lies outside [PC_RESET, PC_RESET+4*IM_DEPTH), pc SHALL hold, the state SHALL become HALT and addr_err SHALL set, all at that edge.
REQ-014 HALT SHALL be terminal until reset; pc holds and addr_err stays 1.
REQ-015 pc SHALL stay at PC_RESET throughout LOAD; the first RUN cycle fetches PC_RESET.
REQ-016 run SHALL be 1 exactly in RUN.
REQ-017 All arithmetic SHALL be 32-bit unsigned with wrap; the range check applies after wrap.
REQ-018 stall SHALL be ignored outside RUN; the REQ-013 check is not applied while stall=1.

Reset
REQ-019 reset=0 SHALL asynchronously force: state LOAD, pc=PC_RESET, ld_ptr=0, addr_err=0, IM cleared, instr=0, run=0, ld_ready=1, pc_plus4=PC_RESET+4.
REQ-020 Reset asserted mid-load or mid-run SHALL discard all loaded words; loading restarts at ld_ptr=0 after release.
REQ-021 After release, the first edge with ld_valid=1 SHALL write IM[0].

Verification
REQ-022 Load 3 words 24010005, 24020007, 00430821 (last on the third) -> run=1 on the next cycle; pc steps 3000, 3004, 3008; instr matches; IM[3]=0.
REQ-023 In RUN at pc=3004 with instr=1000FFFF, npc_sel=01, br_taken=1 -> next pc=3004.
REQ-024 Same instruction with br_taken=0 -> next pc=3008.
REQ-025 npc_sel=11, ra_data=32'h0000_3001 -> HALT, addr_err=1, pc holds, instr=0.
REQ-026 stall=1 for 3 cycles with npc_sel=10 -> pc unchanged, then jumps on the first cycle with stall=0; jump to 00000000 -> HALT.
REQ-027 Assert reset after 2 of 5 load words, release, reload 1 word with ld_last -> IM[0]=new word, IM[1]=0, pc=3000.

Source files
------------

// File: rtl/ifu_boot.sv
// ifu_boot: boot-time instruction loader and fetch unit.
//
// After reset the block sits in LOAD and accepts a stream of 32-bit instruction
// words into an on-chip instruction memory. The last word (ld_last, or the word
// that fills the memory) switches it to RUN, where it fetches from pc and steps
// pc by sequential, branch, jump or register-indirect rules. A next pc that is
// misaligned or outside the memory window parks the block in HALT with a sticky
// addr_err until the next reset.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset (clears state and the whole memory)
//   ld_valid  loader word valid
//   ld_data   loader instruction word
//   ld_last   final loader word, qualified by ld_valid
//   ld_ready  high while the block accepts loader words (LOAD)
//   stall     hold pc this cycle (RUN only)
//   npc_sel   next-pc source: 00 seq, 01 branch, 10 jump, 11 jr
//   br_taken  branch condition result
//   ra_data   jr target register value
//   instr     instruction at pc (zero outside RUN)
//   pc        current fetch address
//   pc_plus4  pc + 4
//   run       high in RUN
//   addr_err  sticky fetch-address error
module ifu_boot #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int unsigned IM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [31:0] ra_data,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        run,
    output logic        addr_err
);

    localparam int unsigned   PW       = (IM_DEPTH > 1) ? $clog2(IM_DEPTH) : 1;
    localparam logic [32:0]   IM_BYTES = 33'(IM_DEPTH) << 2;
    localparam logic [PW-1:0] PTR_LAST = PW'(IM_DEPTH - 1);

    typedef enum logic [1:0] {StLoad, StRun, StHalt} state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          err_q, err_d;
    logic          im_we;

    logic [31:0]   im [IM_DEPTH];

    logic [31:0]   pc_off;
    logic [31:0]   br_off;
    logic [31:0]   npc;
    logic [31:0]   npc_off;
    logic          npc_bad;
    logic          unused_pc_off;

    // Word index into the memory; only meaningful in RUN, where pc is known
    // to be aligned and inside the window.
    assign pc_off        = pc_q - PC_RESET;
    assign unused_pc_off = ^{pc_off[31:PW+2], pc_off[1:0]};

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + 32'd4;
    assign run      = (state_q == StRun);
    assign ld_ready = (state_q == StLoad);
    assign addr_err = err_q;
    assign instr    = run ? im[pc_off[PW+1:2]] : 32'h0000_0000;

    assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        npc = pc_plus4;
        unique case (npc_sel)
            2'b00: npc = pc_plus4;
            2'b01: npc = br_taken ? (pc_plus4 + br_off) : pc_plus4;
            2'b10: npc = {pc_plus4[31:28], instr[25:0], 2'b00};
            2'b11: npc = ra_data;
            default: npc = pc_plus4;
        endcase
    end

    // Window check after wrap: anything below PC_RESET wraps to a huge offset.
    assign npc_off = npc - PC_RESET;
    assign npc_bad = (npc[1:0] != 2'b00) || ({1'b0, npc_off} >= IM_BYTES);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ptr_d   = ptr_q;
        err_d   = err_q;
        im_we   = 1'b0;
        unique case (state_q)
            StLoad: begin
                if (ld_valid) begin
                    im_we = 1'b1;
                    ptr_d = ptr_q + PW'(1);
                    if (ld_last || (ptr_q == PTR_LAST)) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (!stall) begin
                    if (npc_bad) begin
                        state_d = StHalt;
                        err_d   = 1'b1;
                    end else begin
                        pc_d = npc;
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StLoad;
            pc_q    <= PC_RESET;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    // Whole memory clears on reset so unwritten words fetch as nop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(IM_DEPTH); i++) begin
                im[i] <= 32'h0000_0000;
            end
        end else if (im_we) begin
            im[ptr_q] <= ld_data;
        end
    end

endmodule

// File: tb/tb_ifu_boot.sv
module tb_ifu_boot;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam int          IM_DEPTH = 16;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data  = '0;
    logic        ld_last  = 1'b0;
    logic        stall    = 1'b0;
    logic [1:0]  npc_sel  = 2'b00;
    logic        br_taken = 1'b0;
    logic [31:0] ra_data  = '0;
    logic        ld_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        run;
    logic        addr_err;

    ifu_boot #(
        .PC_RESET(PC_RESET),
        .IM_DEPTH(IM_DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .stall    (stall),
        .npc_sel  (npc_sel),
        .br_taken (br_taken),
        .ra_data  (ra_data),
        .instr    (instr),
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .run      (run),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
        logic        run;
        logic        ld_ready;
        logic        addr_err;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: memory contents, words loaded so far, mode 0/1/2 for
    // LOAD/RUN/HALT, fetch address and the error flag.
    logic [31:0] m_mem [IM_DEPTH];
    int          m_fill;
    int          m_mode;
    logic [31:0] m_pc;
    bit          m_err;

    function automatic void m_reset();
        for (int i = 0; i < IM_DEPTH; i++) m_mem[i] = 32'h0;
        m_fill = 0;
        m_mode = 0;
        m_pc   = PC_RESET;
        m_err  = 1'b0;
    endfunction

    function automatic logic [31:0] m_instr();
        if (m_mode != 1) return 32'h0;
        return m_mem[(m_pc - PC_RESET) / 4];
    endfunction

    function automatic void m_step(bit v, logic [31:0] d, bit last, bit st,
                                   logic [1:0] sel, bit bt, logic [31:0] ra);
        logic [31:0] ins;
        logic [31:0] seq;
        logic [31:0] nxt;
        if (m_mode == 0) begin
            if (v) begin
                m_mem[m_fill] = d;
                m_fill++;
                if (last || m_fill == IM_DEPTH) m_mode = 1;
            end
        end else if (m_mode == 1 && !st) begin
            ins = m_instr();
            seq = m_pc + 32'd4;
            case (sel)
                2'd0: nxt = seq;
                2'd1: nxt = bt ? seq + 32'($signed(ins[15:0])) * 32'd4 : seq;
                2'd2: nxt = (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
                default: nxt = ra;
            endcase
            if ((nxt % 4) != 0 || nxt < PC_RESET ||
                longint'(nxt) >= longint'(PC_RESET) + 4 * IM_DEPTH) begin
                m_mode = 2;
                m_err  = 1'b1;
            end else begin
                m_pc = nxt;
            end
        end
    endfunction

    // One clock of stimulus; the expected post-edge outputs go on the scoreboard.
    task automatic cycle(bit rst_n, bit v, logic [31:0] d, bit last, bit st,
                         logic [1:0] sel, bit bt, logic [31:0] ra);
        exp_t e;
        @(negedge clk);
        reset    = rst_n;
        ld_valid = v;
        ld_data  = d;
        ld_last  = last;
        stall    = st;
        npc_sel  = sel;
        br_taken = bt;
        ra_data  = ra;
        if (!rst_n) m_reset();
        else m_step(v, d, last, st, sel, bt, ra);
        e.pc       = m_pc;
        e.pc_plus4 = m_pc + 32'd4;
        e.instr    = m_instr();
        e.run      = (m_mode == 1);
        e.ld_ready = (m_mode == 0);
        e.addr_err = m_err;
        e.id       = cyc;
        sb.push_back(e);
        cyc++;
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0);
    endtask

    task automatic load_word(logic [31:0] d, bit last);
        cycle(1'b1, 1'b1, d, last, 1'b0, 2'd0, 1'b0, 32'h0);
    endtask

    task automatic step(logic [1:0] sel, bit st, bit bt, logic [31:0] ra);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, st, sel, bt, ra);
    endtask

    function automatic logic [31:0] gen_word();
        int          o;
        logic [31:0] w;
        case ($urandom_range(0, 2))
            0: begin
                o = int'($urandom_range(0, 6)) - 3;
                w = {16'h1000, o[15:0]};
            end
            1: begin
                w = (PC_RESET >> 2) + $urandom_range(0, IM_DEPTH);
                w = {6'h02, w[25:0]};
            end
            default: w = $urandom;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] gen_ra();
        logic [31:0] r;
        r = PC_RESET + 4 * $urandom_range(0, IM_DEPTH);
        case ($urandom_range(0, 7))
            0: r = r + $urandom_range(1, 3);
            1: r = PC_RESET - 32'd4;
            default: ;
        endcase
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp, int id);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, id, act, exp);
        end
    endtask

    // Monitor: every sampled cycle that has a pending expectation is compared.
    exp_t got;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                got = sb.pop_front();
                chk("pc", pc, got.pc, got.id);
                chk("pc_plus4", pc_plus4, got.pc_plus4, got.id);
                chk("instr", instr, got.instr, got.id);
                chk("run", 32'(run), 32'(got.run), got.id);
                chk("ld_ready", 32'(ld_ready), 32'(got.ld_ready), got.id);
                chk("addr_err", 32'(addr_err), 32'(got.addr_err), got.id);
            end
        end
    end

    initial begin
        int guard;
        m_reset();
        do_reset();
        do_reset();

        // Three-word program, sequential fetch past the end, then misaligned jr.
        load_word(32'h2401_0005, 1'b0);
        load_word(32'h2402_0007, 1'b0);
        load_word(32'h0043_0821, 1'b1);
        repeat (4) step(2'd0, 1'b0, 1'b0, 32'h0);
        step(2'd3, 1'b0, 1'b0, 32'h0000_3001);
        cycle(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0);
        step(2'd0, 1'b0, 1'b0, 32'h0);

        // Branch-to-self, not taken, stalled jump, jump back, jump to zero.
        do_reset();
        load_word(32'h2401_0005, 1'b0);
        load_word(32'h1000_FFFF, 1'b0);
        load_word(32'h0800_0C00, 1'b0);
        load_word(32'h0800_0000, 1'b1);
        step(2'd0, 1'b0, 1'b0, 32'h0);
        step(2'd1, 1'b0, 1'b1, 32'h0);
        step(2'd1, 1'b0, 1'b0, 32'h0);
        repeat (3) step(2'd2, 1'b1, 1'b0, 32'h0);
        step(2'd2, 1'b0, 1'b0, 32'h0);
        step(2'd0, 1'b0, 1'b0, 32'h0);
        step(2'd1, 1'b0, 1'b0, 32'h0);
        step(2'd0, 1'b0, 1'b0, 32'h0);
        repeat (3) step(2'd2, 1'b1, 1'b0, 32'h0);
        step(2'd2, 1'b0, 1'b0, 32'h0);
        step(2'd0, 1'b0, 1'b0, 32'h0);

        // Reset mid-load discards words; reload a single word.
        do_reset();
        load_word(32'h1111_1111, 1'b0);
        load_word(32'h2222_2222, 1'b0);
        do_reset();
        load_word(32'h3333_3333, 1'b1);
        repeat (2) step(2'd0, 1'b0, 1'b0, 32'h0);

        // Fill the memory without ld_last; run off the top of the window.
        do_reset();
        for (int i = 0; i < IM_DEPTH; i++) load_word(32'h0000_1000 + 32'(i), 1'b0);
        cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0);
        repeat (IM_DEPTH) step(2'd0, 1'b0, 1'b0, 32'h0);
        step(2'd0, 1'b0, 1'b0, 32'h0);

        // Randomized programs and control.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            guard = 0;
            while (m_mode == 0 && guard < 100) begin
                cycle(1'b1, ($urandom_range(0, 3) != 0), gen_word(),
                      ($urandom_range(0, 9) == 0), 1'($urandom), 2'($urandom),
                      1'($urandom), 32'h0);
                guard++;
            end
            for (int k = 0; k < 60; k++) begin
                cycle(($urandom_range(0, 99) != 0), 1'($urandom), $urandom, 1'($urandom),
                      ($urandom_range(0, 3) == 0), 2'($urandom), 1'($urandom), gen_ra());
            end
        end

        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
